// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU significand pre-normalizer and its rounder interface.
// Raw significands carry two integer bits (105:104) above a 104-bit fraction.
package fpu_pkg;

  localparam int RAW_W    = 106;
  localparam int F1_W     = 55;
  localparam int EXP_W    = 13;
  localparam int EMIN_DBL = -1022;
  localparam int EMIN_SGL = -126;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_NORM   = 2'd1,
    ST_DENORM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic                    s;
    logic                    db;
    logic [RAW_W-1:0]        sig;
    logic signed [EXP_W-1:0] e;
    logic                    sticky;
  } op_t;

  // Rounder wants kept bits, one guard bit, and a sticky that folds in everything below.
  function automatic logic [F1_W-1:0] pack_f1(input logic [RAW_W-1:0] sig,
                                              input logic sticky,
                                              input logic db);
    logic [F1_W-1:0] f;
    f = '0;
    if (db) begin
      f[54:2] = sig[104:52];
      f[1]    = sig[51];
      f[0]    = (|sig[50:0]) | sticky;
    end else begin
      f[54:31] = sig[104:81];
      f[30]    = sig[80];
      f[29]    = (|sig[79:0]) | sticky;
    end
    return f;
  endfunction

endpackage

// File: rtl/lzc106.sv
// Combinational leading-zero count over the fraction-aligned bits 104..0 of a raw significand.
// Returns 105 when every bit is clear.
module lzc106
  import fpu_pkg::*;
(
  input  logic [RAW_W-2:0] din,
  output logic [6:0]       lz
);

  logic found;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = RAW_W - 2; i >= 0; i--) begin
      if (!found) begin
        if (din[i]) found = 1'b1;
        else        lz    = lz + 7'd1;
      end
    end
  end

endmodule

// File: rtl/sig_prenorm.sv
// Normalizes or denormalizes one significand at a time into rounder f1 format; latency 1 (zero) or 2 + ceil(shift/SHIFT_STEP).
// in_ready only in IDLE; a finished result is held stable in DONE until out_ready.
module sig_prenorm
  import fpu_pkg::*;
#(
  parameter int SHIFT_STEP = 16,
  parameter int EW         = EXP_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_s,
  input  logic                 in_db,
  input  logic [RAW_W-1:0]     in_sig,
  input  logic signed [EW-1:0] in_e,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_s,
  output logic                 out_db,
  output logic [F1_W-1:0]      out_f1,
  output logic signed [EW-1:0] out_e,
  output logic                 out_zero,
  output logic                 out_tiny
);

  localparam logic [6:0]              STEP7  = 7'(SHIFT_STEP);
  localparam logic signed [EXP_W:0]   STEP_X = (EXP_W+1)'(SHIFT_STEP);

  state_e state_q, state_d;
  op_t    op_q, op_d;

  logic                    out_valid_q, out_valid_d;
  logic                    out_s_q, out_s_d;
  logic                    out_db_q, out_db_d;
  logic [F1_W-1:0]         out_f1_q, out_f1_d;
  logic signed [EXP_W-1:0] out_e_q, out_e_d;
  logic                    out_zero_q, out_zero_d;
  logic                    out_tiny_q, out_tiny_d;

  logic signed [EXP_W-1:0] e_in, emin_in, acc_e, emin_cur, sh_e;
  logic [RAW_W-1:0]        acc_sig, lost_mask;
  logic                    acc_sticky;
  logic signed [EXP_W:0]   e_x, emin_x, room;
  logic [6:0]              lz, lim, sh;

  lzc106 u_lzc (
    .din (op_q.sig[RAW_W-2:0]),
    .lz  (lz)
  );

  // A carry into bit 105 is folded at accept time so NORM only ever shifts left.
  always_comb begin
    e_in    = EXP_W'(in_e);
    emin_in = in_db ? EXP_W'(EMIN_DBL) : EXP_W'(EMIN_SGL);
    if (in_sig[RAW_W-1]) begin
      acc_sig    = in_sig >> 1;
      acc_sticky = in_sig[0];
      acc_e      = e_in + EXP_W'(1);
    end else begin
      acc_sig    = in_sig;
      acc_sticky = 1'b0;
      acc_e      = e_in;
    end
  end

  // Per-cycle shift: bounded by the step size and by the distance to emin.
  always_comb begin
    emin_cur = op_q.db ? EXP_W'(EMIN_DBL) : EXP_W'(EMIN_SGL);
    e_x      = (EXP_W+1)'($signed(op_q.e));
    emin_x   = (EXP_W+1)'(emin_cur);
    room     = (state_q == ST_DENORM) ? (emin_x - e_x) : (e_x - emin_x);
    lim      = (room > STEP_X) ? STEP7 : room[6:0];
    sh       = '0;
    if (state_q == ST_NORM)   sh = (lz < lim) ? lz : lim;
    if (state_q == ST_DENORM) sh = lim;
    sh_e      = $signed({{(EXP_W-7){1'b0}}, sh});
    lost_mask = ~({RAW_W{1'b1}} << sh);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_sig == '0)         state_d = ST_DONE;
          else if (acc_e < emin_in) state_d = ST_DENORM;
          else                      state_d = ST_NORM;
        end
      end
      ST_NORM, ST_DENORM: if (sh == 7'd0) state_d = ST_DONE;
      ST_DONE:            if (out_ready)  state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == ST_IDLE);
    op_d        = op_q;
    out_valid_d = out_valid_q;
    out_s_d     = out_s_q;
    out_db_d    = out_db_q;
    out_f1_d    = out_f1_q;
    out_e_d     = out_e_q;
    out_zero_d  = out_zero_q;
    out_tiny_d  = out_tiny_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d.s      = in_s;
          op_d.db     = in_db;
          op_d.sig    = acc_sig;
          op_d.e      = acc_e;
          op_d.sticky = acc_sticky;
          if (in_sig == '0) begin
            out_valid_d = 1'b1;
            out_s_d     = in_s;
            out_db_d    = in_db;
            out_f1_d    = '0;
            out_e_d     = emin_in;
            out_zero_d  = 1'b1;
            out_tiny_d  = 1'b0;
          end
        end
      end
      ST_NORM, ST_DENORM: begin
        if (sh == 7'd0) begin
          out_valid_d = 1'b1;
          out_s_d     = op_q.s;
          out_db_d    = op_q.db;
          out_f1_d    = pack_f1(op_q.sig, op_q.sticky, op_q.db);
          out_e_d     = op_q.e;
          out_zero_d  = 1'b0;
          out_tiny_d  = ~op_q.sig[RAW_W-2];
        end else if (state_q == ST_NORM) begin
          op_d.sig = op_q.sig << sh;
          op_d.e   = op_q.e - sh_e;
        end else begin
          op_d.sig    = op_q.sig >> sh;
          op_d.sticky = op_q.sticky | (|(op_q.sig & lost_mask));
          op_d.e      = op_q.e + sh_e;
        end
      end
      ST_DONE: if (out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      out_s_q     <= 1'b0;
      out_db_q    <= 1'b0;
      out_f1_q    <= '0;
      out_e_q     <= '0;
      out_zero_q  <= 1'b0;
      out_tiny_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      out_s_q     <= out_s_d;
      out_db_q    <= out_db_d;
      out_f1_q    <= out_f1_d;
      out_e_q     <= out_e_d;
      out_zero_q  <= out_zero_d;
      out_tiny_q  <= out_tiny_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_db    = out_db_q;
  assign out_f1    = out_f1_q;
  assign out_e     = EW'(out_e_q);
  assign out_zero  = out_zero_q;
  assign out_tiny  = out_tiny_q;

endmodule
